control_fsm: RTL
================

Name: control_fsm

Overview:
- Multicycle control unit that drives the ADD/SUB/load/store datapath.
- Fetches 32-bit RV64I instructions over a req/ack instruction-memory handshake and decodes them.
- Sequences the datapath control inputs: register selects, immediate, sub, WE_RF, WE_MEM, RF_din_sel, ULA_din2_sel.
- Keeps the PC and a retired-instruction counter.
- Supported instructions: ADD, SUB, ADDI, LD, SD, ECALL (halt); anything else traps.

Parameters:
- PC_WIDTH, 64, width of PC and imem_addr.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- imem_req  out  1  fetch request; held high until imem_ack.
- imem_addr  out  PC_WIDTH  fetch address (= PC); stable while imem_req is high.
- imem_ack  in  1  instruction valid this cycle; ignored when imem_req is low.
- imem_data  in  32  instruction word, sampled when imem_req and imem_ack are both high.
- rs1  out  5  register-file read select A.
- rs2  out  5  register-file read select B.
- rd  out  5  register-file write select.
- immediate  out  12  I-type or S-type immediate, unextended.
- sub  out  1  ALU subtract.
- WE_RF  out  1  register-file write enable.
- WE_MEM  out  1  data-memory write enable.
- RF_din_sel  out  1  1 = ALU result to register file, 0 = memory data.
- ULA_din2_sel  out  1  1 = immediate as ALU operand 2, 0 = rs2 data.
- halted  out  1  sticky; ECALL executed.
- illegal  out  1  sticky; unsupported encoding fetched.
- instret  out  64  count of retired instructions.

Behaviour:
- Reset (asynchronous, active-high):
  - state=FETCH, PC=RESET_PC, IR=0, instret=0.
  - All outputs 0: imem_req, WE_RF, WE_MEM, sub, both selects, halted, illegal.
  - Reset mid-fetch drops imem_req immediately; a late imem_ack is ignored.
- States: FETCH, DECODE, EXEC, MEM, COMMIT, HALT, TRAP. All outputs are registered.
- FETCH:
  - imem_req=1.
  - On imem_ack: IR<=imem_data, go to DECODE.
  - No timeout; waits indefinitely.
- DECODE (1 cycle): classify IR, drive rs1/rs2/rd/immediate/sub/selects from IR.
  - ADD: opcode 0110011, funct3 000, funct7 0000000. sub=0, ULA_din2_sel=0, RF_din_sel=1.
  - SUB: same as ADD but funct7 0100000; sub=1.
  - ADDI: opcode 0010011, funct3 000. immediate=IR[31:20], ULA_din2_sel=1, RF_din_sel=1.
  - LD: opcode 0000011, funct3 011. immediate=IR[31:20], ULA_din2_sel=1, RF_din_sel=0.
  - SD: opcode 0100011, funct3 011. immediate={IR[31:25],IR[11:7]}, ULA_din2_sel=1.
  - ECALL: IR==0x00000073, go to HALT.
  - Anything else: go to TRAP.
- EXEC (1 cycle, ALU settle):
  - LD goes to MEM; all others go to COMMIT.
- MEM (1 cycle): memory read settle before writeback.
- COMMIT (exactly 1 cycle):
  - ALU ops and LD: WE_RF=1, except WE_RF=0 when rd==0.
  - SD: WE_MEM=1.
  - On exit: PC<=PC+4 (wraps modulo 2^PC_WIDTH), instret+=1, go to FETCH.
- Write enables are high only in COMMIT; never high in any other state.
- Selects and register fields are held constant from DECODE through COMMIT.
- Latency from ack to COMMIT: 3 cycles for R/I/SD, 4 cycles for LD.
- HALT: halted=1, imem_req=0, PC frozen; exit only via RST. ECALL does not increment instret.
- TRAP: illegal=1, otherwise identical to HALT (halted stays 0). PC holds the address of the faulting instruction.

Decomposition:
- Shared package riscv_pkg: opcode constants (OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_SYSTEM), funct3/funct7 constants, state encoding.
- One natural sub-module: instr_decoder. It is combinational IR-to-control-fields logic with a class output (ALU/LOAD/STORE/HALT/ILLEGAL); the FSM registers its outputs.

Test Plan:
- Reset with RESET_PC=0 -> imem_req=1 and imem_addr=0 in the first cycle after release. Assert RST mid-FETCH -> imem_req=0 immediately.
- Fetch 0x00500093 (addi x1,x0,5) -> rd=1, rs1=0, immediate=0x005, ULA_din2_sel=1, RF_din_sel=1. WE_RF high for exactly one cycle, 3 cycles after ack. Next imem_addr=4, instret=1.
- Fetch 0x002081B3 then 0x402081B3 -> add: sub=0; sub: sub=1. Both have rd=3, rs1=1, rs2=2, ULA_din2_sel=0 and one WE_RF pulse each.
- Fetch 0x0080B203 (ld x4,8(x1)) -> immediate=0x008, RF_din_sel=0, WE_RF pulse 4 cycles after ack. Fetch 0x0020B823 (sd x2,16(x1)) -> immediate=0x010, WE_MEM pulse, WE_RF=0.
- Fetch 0x00000013 variant with rd=0 (addi x0,x0,1 = 0x00100013) -> no WE_RF pulse, instret still increments. Insert imem_ack delays of 0/5 cycles -> identical control results.
- Fetch 0xFFFFFFFF -> illegal=1, imem_req stays 0, PC unchanged. Fetch 0x00000073 -> halted=1, instret unchanged. Both hold until RST.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared encodings for the multicycle control unit: RV64I opcode and
// funct fields, FSM state encoding and the decoder's instruction classes.
package riscv_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [2:0] F3_ADD    = 3'b000;
    localparam logic [2:0] F3_DWORD  = 3'b011;

    localparam logic [6:0] F7_ADD    = 7'b0000000;
    localparam logic [6:0] F7_SUB    = 7'b0100000;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_COMMIT,
        S_HALT,
        S_TRAP
    } state_t;

    typedef enum logic [2:0] {
        CL_ALU,
        CL_LOAD,
        CL_STORE,
        CL_HALT,
        CL_ILLEGAL
    } iclass_t;

    // Classes whose result is written back to the register file.
    function automatic logic writes_rf(input iclass_t cls);
        return (cls == CL_ALU) || (cls == CL_LOAD);
    endfunction

endpackage

// File: rtl/control_fsm_if.sv
// Instruction-memory fetch handshake: the control unit is the master,
// raising imem_req with a stable imem_addr until the memory acks.
interface control_fsm_if #(
    parameter int PC_WIDTH = 64
);
    logic                imem_req;
    logic [PC_WIDTH-1:0] imem_addr;
    logic                imem_ack;
    logic [31:0]         imem_data;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_data
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_data
    );
endinterface

// File: rtl/control_fsm_instr_decoder.sv
// Combinational IR decode: extracts register fields, immediate and datapath
// selects, and classifies the instruction for the control FSM.
module instr_decoder
    import riscv_pkg::*;
(
    input  logic [31:0] ir_i,
    output iclass_t     cls_o,
    output logic [4:0]  rs1_o,
    output logic [4:0]  rs2_o,
    output logic [4:0]  rd_o,
    output logic [11:0] imm_o,
    output logic        sub_o,
    output logic        rf_din_sel_o,
    output logic        ula_din2_sel_o
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;

    assign opcode = ir_i[6:0];
    assign funct3 = ir_i[14:12];
    assign funct7 = ir_i[31:25];

    // Register fields sit at fixed positions for every supported format.
    assign rs1_o = ir_i[19:15];
    assign rs2_o = ir_i[24:20];
    assign rd_o  = ir_i[11:7];

    // Classify the instruction and derive immediate and operand selects.
    always_comb begin
        cls_o          = CL_ILLEGAL;
        imm_o          = '0;
        sub_o          = 1'b0;
        rf_din_sel_o   = 1'b0;
        ula_din2_sel_o = 1'b0;
        case (opcode)
            OP_R: begin
                if (funct3 == F3_ADD && funct7 == F7_ADD) begin
                    cls_o        = CL_ALU;
                    rf_din_sel_o = 1'b1;
                end else if (funct3 == F3_ADD && funct7 == F7_SUB) begin
                    cls_o        = CL_ALU;
                    sub_o        = 1'b1;
                    rf_din_sel_o = 1'b1;
                end
            end
            OP_IMM: begin
                if (funct3 == F3_ADD) begin
                    cls_o          = CL_ALU;
                    imm_o          = ir_i[31:20];
                    ula_din2_sel_o = 1'b1;
                    rf_din_sel_o   = 1'b1;
                end
            end
            OP_LOAD: begin
                if (funct3 == F3_DWORD) begin
                    cls_o          = CL_LOAD;
                    imm_o          = ir_i[31:20];
                    ula_din2_sel_o = 1'b1;
                end
            end
            OP_STORE: begin
                if (funct3 == F3_DWORD) begin
                    cls_o          = CL_STORE;
                    imm_o          = {ir_i[31:25], ir_i[11:7]};
                    ula_din2_sel_o = 1'b1;
                end
            end
            OP_SYSTEM: begin
                // Only the exact ECALL encoding halts; any other SYSTEM word traps.
                if (ir_i[31:7] == 25'd0) begin
                    cls_o = CL_HALT;
                end
            end
            default: begin
                cls_o = CL_ILLEGAL;
            end
        endcase
    end

endmodule

// File: rtl/control_fsm.sv
// Multicycle control unit for the ADD/SUB/load/store datapath: fetches over
// the imem handshake, decodes, and sequences registered control outputs.
module control_fsm
    import riscv_pkg::*;
#(
    parameter int                  PC_WIDTH = 64,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic              CLK,
    input  logic              RST,
    control_fsm_if.master     imem,
    output logic [4:0]        rs1,
    output logic [4:0]        rs2,
    output logic [4:0]        rd,
    output logic [11:0]       immediate,
    output logic              sub,
    output logic              WE_RF,
    output logic              WE_MEM,
    output logic              RF_din_sel,
    output logic              ULA_din2_sel,
    output logic              halted,
    output logic              illegal,
    output logic [63:0]       instret
);

    state_t              state_q, state_d;
    logic [31:0]         ir_q;
    logic [PC_WIDTH-1:0] pc_q;
    logic [63:0]         instret_q;
    iclass_t             cls_q, cls_d;

    logic                req_q, req_d;
    logic [4:0]          rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
    logic [11:0]         imm_q, imm_d;
    logic                sub_q, sub_d;
    logic                we_rf_q, we_rf_d, we_mem_q, we_mem_d;
    logic                rf_sel_q, rf_sel_d, ula_sel_q, ula_sel_d;
    logic                halted_q, halted_d, illegal_q, illegal_d;

    iclass_t             dec_cls;
    logic [4:0]          dec_rs1, dec_rs2, dec_rd;
    logic [11:0]         dec_imm;
    logic                dec_sub, dec_rf_sel, dec_ula_sel;
    logic                fetch_fire;

    instr_decoder u_dec (
        .ir_i           (ir_q),
        .cls_o          (dec_cls),
        .rs1_o          (dec_rs1),
        .rs2_o          (dec_rs2),
        .rd_o           (dec_rd),
        .imm_o          (dec_imm),
        .sub_o          (dec_sub),
        .rf_din_sel_o   (dec_rf_sel),
        .ula_din2_sel_o (dec_ula_sel)
    );

    // An ack only counts while our own registered request is up.
    assign fetch_fire = (state_q == S_FETCH) && req_q && imem.imem_ack;

    // State register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  if (fetch_fire) state_d = S_DECODE;
            S_DECODE: begin
                case (dec_cls)
                    CL_ALU, CL_LOAD, CL_STORE: state_d = S_EXEC;
                    CL_HALT:                   state_d = S_HALT;
                    default:                   state_d = S_TRAP;
                endcase
            end
            S_EXEC:   state_d = (cls_q == CL_LOAD) ? S_MEM : S_COMMIT;
            S_MEM:    state_d = S_COMMIT;
            S_COMMIT: state_d = S_FETCH;
            S_HALT:   state_d = S_HALT;
            S_TRAP:   state_d = S_TRAP;
            default:  state_d = S_FETCH;
        endcase
    end

    // Output logic: next values of the registered outputs, keyed on the state being entered.
    always_comb begin
        rs1_d     = rs1_q;
        rs2_d     = rs2_q;
        rd_d      = rd_q;
        imm_d     = imm_q;
        sub_d     = sub_q;
        rf_sel_d  = rf_sel_q;
        ula_sel_d = ula_sel_q;
        cls_d     = cls_q;
        if (state_q == S_DECODE) begin
            rs1_d     = dec_rs1;
            rs2_d     = dec_rs2;
            rd_d      = dec_rd;
            imm_d     = dec_imm;
            sub_d     = dec_sub;
            rf_sel_d  = dec_rf_sel;
            ula_sel_d = dec_ula_sel;
            cls_d     = dec_cls;
        end
        req_d     = (state_d == S_FETCH);
        // Writes to x0 are suppressed so the datapath never sees a WE on it.
        we_rf_d   = (state_d == S_COMMIT) && writes_rf(cls_q) && (rd_q != 5'd0);
        we_mem_d  = (state_d == S_COMMIT) && (cls_q == CL_STORE);
        halted_d  = halted_q  || (state_d == S_HALT);
        illegal_d = illegal_q || (state_d == S_TRAP);
    end

    // Output registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            req_q     <= 1'b0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            rd_q      <= '0;
            imm_q     <= '0;
            sub_q     <= 1'b0;
            rf_sel_q  <= 1'b0;
            ula_sel_q <= 1'b0;
            cls_q     <= CL_ALU;
            we_rf_q   <= 1'b0;
            we_mem_q  <= 1'b0;
            halted_q  <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            req_q     <= req_d;
            rs1_q     <= rs1_d;
            rs2_q     <= rs2_d;
            rd_q      <= rd_d;
            imm_q     <= imm_d;
            sub_q     <= sub_d;
            rf_sel_q  <= rf_sel_d;
            ula_sel_q <= ula_sel_d;
            cls_q     <= cls_d;
            we_rf_q   <= we_rf_d;
            we_mem_q  <= we_mem_d;
            halted_q  <= halted_d;
            illegal_q <= illegal_d;
        end
    end

    // Architectural state: IR capture on fetch, PC and retire count advance on leaving COMMIT.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ir_q      <= '0;
            pc_q      <= RESET_PC;
            instret_q <= '0;
        end else begin
            if (fetch_fire) begin
                ir_q <= imem.imem_data;
            end
            if (state_q == S_COMMIT) begin
                pc_q      <= pc_q + PC_WIDTH'(4);
                instret_q <= instret_q + 64'd1;
            end
        end
    end

    assign imem.imem_req  = req_q;
    assign imem.imem_addr = pc_q;
    assign rs1            = rs1_q;
    assign rs2            = rs2_q;
    assign rd             = rd_q;
    assign immediate      = imm_q;
    assign sub            = sub_q;
    assign WE_RF          = we_rf_q;
    assign WE_MEM         = we_mem_q;
    assign RF_din_sel     = rf_sel_q;
    assign ULA_din2_sel   = ula_sel_q;
    assign halted         = halted_q;
    assign illegal        = illegal_q;
    assign instret        = instret_q;

endmodule
